// File: rtl/uart_tx_frame_if.sv
// Character source <-> UART transmitter: handshake, character and its framing config.
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_len;
  logic       cfg_stop2;
  logic       cfg_baud_hi;
  logic [1:0] cfg_parity;

  modport master (
    output tx_data, tx_valid, cfg_len, cfg_stop2, cfg_baud_hi, cfg_parity,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, cfg_len, cfg_stop2, cfg_baud_hi, cfg_parity,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: synchronous UART transmitter, 5..8 data bits, 1/2 stop bits,
// two selectable baud rates, RTS high for the duration of each frame.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD_LO = 2400,
  parameter int unsigned BAUD_HI = 9600,
  parameter int unsigned DIV_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  tx,
  output logic            txd,
  output logic            rts,
  output logic            busy
);

  localparam int unsigned DIV_LO = CLK_HZ / BAUD_LO;
  localparam int unsigned DIV_HI = CLK_HZ / BAUD_HI;
  localparam logic [DIV_W-1:0] LAST_LO = DIV_W'(DIV_LO - 1);
  localparam logic [DIV_W-1:0] LAST_HI = DIV_W'(DIV_HI - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;   // first of two stop bits already sent
  logic [7:0]       data_q;
  logic [1:0]       len_q;
  logic             stop2_q;
  logic             baud_q;
  logic             txd_d, rts_d, ready_d;
  logic             accept;
  logic             bit_done;
  logic             par_en;
  logic [2:0]       last_idx;

`ifdef UART_TX_PARITY_EN
  logic [1:0]       par_q;
  logic             par_bit;
  logic [7:0]       par_mask;

  assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);
  assign par_mask = 8'(8'hFF >> (2'd3 - len_q));
  assign par_bit  = (^(data_q & par_mask)) ^ (par_q == 2'b10);
`else
  assign par_en   = 1'b0;
`endif

  assign accept   = tx.tx_valid & tx.tx_ready;
  assign bit_done = (cnt_q == (baud_q ? LAST_HI : LAST_LO));
  assign last_idx = 3'd4 + 3'(len_q);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      txd         <= 1'b1;
      rts         <= 1'b0;
      tx.tx_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      txd         <= txd_d;
      rts         <= rts_d;
      tx.tx_ready <= ready_d;
      busy        <= ~ready_d;
    end
  end

  // Frame parameters captured at accept so mid-frame config changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      len_q   <= '0;
      stop2_q <= 1'b0;
      baud_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= '0;
`endif
    end else if (accept) begin
      data_q  <= tx.tx_data;
      len_q   <= tx.cfg_len;
      stop2_q <= tx.cfg_stop2;
      baud_q  <= tx.cfg_baud_hi;
`ifdef UART_TX_PARITY_EN
      par_q   <= tx.cfg_parity;
`endif
    end
  end

  // Next state and bit/divider counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    if (state_q != IDLE) cnt_d = bit_done ? '0 : cnt_q + DIV_W'(1);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == last_idx) state_d = par_en ? PARITY : STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (stop2_q && !stop_q) stop_d  = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle after this edge
  always_comb begin
    txd_d   = 1'b1;
    rts_d   = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      IDLE: begin
        rts_d   = 1'b0;
        ready_d = 1'b1;
      end
      START: txd_d = 1'b0;
      DATA:  txd_d = data_q[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_d = par_bit;
`endif
      default: txd_d = 1'b1;
    endcase
  end

endmodule
